aes_spi_sequencer: RTL



---
 rtl/aes_spi_sequencer_pkg.sv | 31 +++
 rtl/aes_serial_shifter.sv | 44 ++++
 rtl/aes_spi_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/aes_spi_sequencer_pkg.sv
// Shared definitions for the AES serial-load sequencer: block width, frame
// timing defaults and the controller state encoding.
package aes_spi_sequencer_pkg;

  // Width of one plaintext/key/result word.
  localparam int BLOCK_W = 128;

  // Frame timing defaults: 128 payload bits plus one flush bit, one gap clock.
  localparam int FRAME_LEN_DEF   = 129;
  localparam int GAP_LEN_DEF     = 1;
  localparam int TIMEOUT_CYC_DEF = 1024;

  // Bit counter width inside the serial shifter.
  localparam int BIT_CNT_W = 8;

  // Controller states, in the order a request walks through them.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_DATA = 3'd1,
    ST_GAP       = 3'd2,
    ST_LOAD_KEY  = 3'd3,
    ST_WAIT      = 3'd4,
    ST_RESP      = 3'd5
  } state_t;

  // True in the two states that drive a serial frame onto mosi.
  function automatic logic is_load_state(input state_t s);
    return (s == ST_LOAD_DATA) || (s == ST_LOAD_KEY);
  endfunction

endpackage

// File: rtl/aes_serial_shifter.sv
// MSB-first parallel-in/serial-out shifter for one 128-bit word. A load
// replaces the word and clears the frame counter; each shift moves the word
// left with zero fill, so once the payload is gone the MSB reads 0 (the flush
// bit). frame_done pulses on the last shift of a FRAME_LEN-clock frame.
module aes_serial_shifter
  import aes_spi_sequencer_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               shift_en,
  output logic               msb,
  output logic               frame_done
);

  logic [BLOCK_W-1:0]   sreg;
  logic [BIT_CNT_W-1:0] bit_cnt;

  // Shift register and frame counter; the counter saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg    <= load_data;
      bit_cnt <= '0;
    end else if (shift_en) begin
      sreg <= {sreg[BLOCK_W-2:0], 1'b0};
      if (bit_cnt != {BIT_CNT_W{1'b1}}) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Serial output and end-of-frame strobe decoded from the registers.
  always_comb begin
    msb        = sreg[BLOCK_W-1];
    frame_done = shift_en && (bit_cnt == BIT_CNT_W'(FRAME_LEN - 1));
  end

endmodule

// File: rtl/aes_spi_sequencer.sv
// Host-side sequencer for the Aes core serial load port. Takes one
// plaintext/key pair per request, shifts the plaintext frame (cs1 low), a
// short gap, then the key frame (cs2 low), waits for both done strobes (or a
// timeout) and hands the captured results back over the response handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only in IDLE and depends on state alone;
// rsp_valid is high only in RESP, and rsp_enc/rsp_dec/rsp_timeout are held
// stable until the edge where rsp_ready is seen high. rsp_ready outside RESP
// and req_valid outside IDLE have no effect.
module aes_spi_sequencer
  import aes_spi_sequencer_pkg::*;
#(
  parameter int FRAME_LEN   = FRAME_LEN_DEF,
  parameter int GAP_LEN     = GAP_LEN_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [BLOCK_W-1:0] req_data,
  input  logic [BLOCK_W-1:0] req_key,
  output logic               cs1,
  output logic               cs2,
  output logic               mosi,
  input  logic               doneenc,
  input  logic               donedec,
  input  logic [BLOCK_W-1:0] encrypted,
  input  logic [BLOCK_W-1:0] decrypted,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BLOCK_W-1:0] rsp_enc,
  output logic [BLOCK_W-1:0] rsp_dec,
  output logic               rsp_timeout,
  output state_t             dbg_state
);

  // Counts gap clocks and wait clocks; wide enough to hold TIMEOUT_CYC.
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  state_t              state_q;
  state_t              state_d;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [BLOCK_W-1:0]  key_q;
  logic                seen_enc;
  logic                seen_dec;

  logic                accept;
  logic                enc_hit;
  logic                dec_hit;
  logic                both_seen;
  logic                sh_load;
  logic [BLOCK_W-1:0]  sh_load_data;
  logic                sh_shift;
  logic                sh_msb;
  logic                sh_frame_done;

  // One shifter serves both frames: loaded with the plaintext on acceptance
  // and reloaded with the held key during the gap.
  aes_serial_shifter #(
    .FRAME_LEN (FRAME_LEN)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (sh_load),
    .load_data  (sh_load_data),
    .shift_en   (sh_shift),
    .msb        (sh_msb),
    .frame_done (sh_frame_done)
  );

  // Handshake, capture and shifter-control decode.
  always_comb begin
    accept       = (state_q == ST_IDLE) && req_valid;
    enc_hit      = (state_q == ST_WAIT) && doneenc && !seen_enc;
    dec_hit      = (state_q == ST_WAIT) && donedec && !seen_dec;
    both_seen    = (seen_enc || doneenc) && (seen_dec || donedec);
    sh_load      = accept || (state_q == ST_GAP);
    sh_load_data = (state_q == ST_GAP) ? key_q : req_data;
    sh_shift     = is_load_state(state_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: walk the frame sequence, then wait for both strobes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD_DATA;
      end
      ST_LOAD_DATA: begin
        if (sh_frame_done) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (wait_cnt == WAIT_W'(GAP_LEN - 1)) state_d = ST_LOAD_KEY;
      end
      ST_LOAD_KEY: begin
        if (sh_frame_done) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (both_seen) begin
          state_d = ST_RESP;
        end else if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gap/wait counter: cleared on every state change, saturates rather than wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_d != state_q) begin
      wait_cnt <= '0;
    end else if ((state_q == ST_GAP) || (state_q == ST_WAIT)) begin
      if (wait_cnt != {WAIT_W{1'b1}}) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Request latch, sticky done flags and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q       <= '0;
      seen_enc    <= 1'b0;
      seen_dec    <= 1'b0;
      rsp_enc     <= '0;
      rsp_dec     <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        // Words not captured before a timeout must read as zero.
        key_q       <= req_key;
        seen_enc    <= 1'b0;
        seen_dec    <= 1'b0;
        rsp_enc     <= '0;
        rsp_dec     <= '0;
        rsp_timeout <= 1'b0;
      end
      if (enc_hit) begin
        seen_enc <= 1'b1;
        rsp_enc  <= encrypted;
      end
      if (dec_hit) begin
        seen_dec <= 1'b1;
        rsp_dec  <= decrypted;
      end
      if ((state_q == ST_WAIT) && (state_d == ST_RESP)) begin
        rsp_timeout <= !both_seen;
      end
      if ((state_q == ST_RESP) && rsp_ready) begin
        seen_enc <= 1'b0;
        seen_dec <= 1'b0;
      end
    end
  end

  // Outputs decoded from state and the shifter register only.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    cs1       = (state_q != ST_LOAD_DATA);
    cs2       = (state_q != ST_LOAD_KEY);
    mosi      = is_load_state(state_q) && sh_msb;
    rsp_valid = (state_q == ST_RESP);
    dbg_state = state_q;
  end

endmodule
